// File: rtl/gshare_bp.sv
// gshare_bp: global-history conditional-branch predictor with init sweep and bypassed registered prediction.
// Define GSHARE_BP_HIST_EN for gshare indexing; without it the block is a plain bimodal predictor.
module gshare_bp #(
  parameter int unsigned VLEN            = 32,
  parameter int unsigned INSTR_PER_FETCH = 2,
  parameter int unsigned NR_ENTRIES      = 1024,
  parameter int unsigned HIST_LEN        = 8,
  parameter int unsigned CTR_BITS        = 2
) (
  input  logic                                            clk_i,
  input  logic                                            rst_i,
  input  logic                                            flush_bp_i,
  input  logic                                            debug_mode_i,
  input  logic [VLEN-1:0]                                 vpc_i,
  input  logic                                            update_valid_i,
  input  logic [VLEN-1:0]                                 update_pc_i,
  input  logic                                            update_taken_i,
  input  logic [$clog2(NR_ENTRIES/INSTR_PER_FETCH)-1:0]   update_index_i,
  output logic [INSTR_PER_FETCH-1:0]                      pred_valid_o,
  output logic [INSTR_PER_FETCH-1:0]                      pred_taken_o,
  output logic [$clog2(NR_ENTRIES/INSTR_PER_FETCH)-1:0]   pred_index_o,
  output logic                                            init_done_o
);
  localparam int unsigned NR_ROWS   = NR_ENTRIES / INSTR_PER_FETCH;
  localparam int unsigned ROW_BITS  = $clog2(NR_ROWS);
  localparam int unsigned BANK_BITS = $clog2(INSTR_PER_FETCH);
  localparam int unsigned BANK_W    = (BANK_BITS == 0) ? 1 : BANK_BITS;
  localparam int unsigned ROW_LSB   = BANK_BITS + 1;
  localparam logic [CTR_BITS-1:0] CTR_INIT = CTR_BITS'((1 << (CTR_BITS - 1)) - 1);
  localparam logic [CTR_BITS-1:0] CTR_MAX  = '1;

  typedef enum logic {ST_INIT, ST_RUN} state_e;

  state_e                      state_q, state_d;
  logic [ROW_BITS-1:0]         cnt_q, cnt_d;
  logic [CTR_BITS-1:0]         table_q [NR_ROWS][INSTR_PER_FETCH];
  logic                        upd_accept;
  logic [ROW_BITS-1:0]         upd_row;
  logic [BANK_W-1:0]           upd_bank;
  logic [CTR_BITS-1:0]         upd_old, upd_new;
  logic [ROW_BITS-1:0]         hfold;
  logic [ROW_BITS-1:0]         pred_row;
  logic [INSTR_PER_FETCH-1:0]  pred_taken_c;
  logic [INSTR_PER_FETCH-1:0]  pred_valid_q, pred_taken_q;
  logic [ROW_BITS-1:0]         pred_index_q;
  logic                        init_done_q;
  logic                        unused_bits;

  assign unused_bits = ^{vpc_i, update_pc_i};

`ifdef GSHARE_BP_HIST_EN
  localparam int unsigned NR_CHUNKS = (HIST_LEN + ROW_BITS - 1) / ROW_BITS;

  logic [HIST_LEN-1:0]           ghr_q;
  logic [NR_CHUNKS*ROW_BITS-1:0] ghr_ext;

  // Fold the zero-extended history into one row-wide hash
  always_comb begin
    ghr_ext = (NR_CHUNKS*ROW_BITS)'(ghr_q);
    hfold   = '0;
    for (int unsigned i = 0; i < NR_CHUNKS; i++) begin
      hfold = hfold ^ ghr_ext[i*ROW_BITS +: ROW_BITS];
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i || flush_bp_i) begin
      ghr_q <= '0;
    end else if (upd_accept) begin
      ghr_q <= HIST_LEN'({ghr_q, update_taken_i});
    end
  end
`else
  assign hfold = '0;
`endif

  // Sweep/run control; flush overrides everything and drops the update
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    upd_accept = 1'b0;
    unique case (state_q)
      ST_INIT: begin
        cnt_d = cnt_q + ROW_BITS'(1);
        if (cnt_q == ROW_BITS'(NR_ROWS - 1)) state_d = ST_RUN;
      end
      ST_RUN:  upd_accept = update_valid_i && !debug_mode_i;
      default: state_d = ST_INIT;
    endcase
    if (flush_bp_i) begin
      state_d    = ST_INIT;
      cnt_d      = '0;
      upd_accept = 1'b0;
    end
  end

  // Saturating counter update and prediction read with write-through bypass
  always_comb begin
    upd_row  = update_index_i;
    upd_bank = BANK_W'((update_pc_i >> 1) & VLEN'(INSTR_PER_FETCH - 1));
    upd_old  = table_q[upd_row][upd_bank];
    if (update_taken_i) begin
      upd_new = (upd_old == CTR_MAX) ? upd_old : upd_old + CTR_BITS'(1);
    end else begin
      upd_new = (upd_old == '0) ? upd_old : upd_old - CTR_BITS'(1);
    end
    pred_row     = vpc_i[ROW_LSB +: ROW_BITS] ^ hfold;
    pred_taken_c = '0;
    for (int unsigned b = 0; b < INSTR_PER_FETCH; b++) begin
      if (upd_accept && upd_row == pred_row && upd_bank == BANK_W'(b)) begin
        pred_taken_c[b] = upd_new[CTR_BITS-1];
      end else begin
        pred_taken_c[b] = table_q[pred_row][b][CTR_BITS-1];
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q      <= ST_INIT;
      cnt_q        <= '0;
      pred_valid_q <= '0;
      pred_taken_q <= '0;
      pred_index_q <= '0;
      init_done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (state_q == ST_RUN && !flush_bp_i) begin
        pred_valid_q <= '1;
        pred_taken_q <= pred_taken_c;
        pred_index_q <= pred_row;
        init_done_q  <= 1'b1;
      end else begin
        pred_valid_q <= '0;
        pred_taken_q <= '0;
        pred_index_q <= '0;
        init_done_q  <= 1'b0;
      end
    end
  end

  // Counter storage: whole-row writes during the sweep, single-entry writes in run
  always_ff @(posedge clk_i) begin
    if (state_q == ST_INIT) begin
      for (int unsigned b = 0; b < INSTR_PER_FETCH; b++) begin
        table_q[cnt_q][b] <= CTR_INIT;
      end
    end else if (upd_accept) begin
      table_q[upd_row][upd_bank] <= upd_new;
    end
  end

  assign pred_valid_o = pred_valid_q;
  assign pred_taken_o = pred_taken_q;
  assign pred_index_o = pred_index_q;
  assign init_done_o  = init_done_q;
endmodule

// File: tb/tb_gshare_bp.sv
// tb_gshare_bp: randomized and directed checks of gshare_bp against a table/array reference model.
// Follows GSHARE_BP_HIST_EN the same way the design does.
module tb_gshare_bp;
  localparam int unsigned NR_ROWS = 512;

  logic        clk = 1'b0;
  logic        rst, flush, dbg, uv, ut;
  logic [31:0] vpc, upc;
  logic [8:0]  uidx;
  logic [1:0]  pred_valid, pred_taken;
  logic [8:0]  pred_index;
  logic        init_done;

  int          n_checks = 0;
  int          n_errors = 0;
  int unsigned mdl_ctr [NR_ROWS][2];
  int unsigned mdl_ghr;
  int          init_left;

  always #5 clk = ~clk;

  gshare_bp dut (
    .clk_i          (clk),
    .rst_i          (rst),
    .flush_bp_i     (flush),
    .debug_mode_i   (dbg),
    .vpc_i          (vpc),
    .update_valid_i (uv),
    .update_pc_i    (upc),
    .update_taken_i (ut),
    .update_index_i (uidx),
    .pred_valid_o   (pred_valid),
    .pred_taken_o   (pred_taken),
    .pred_index_o   (pred_index),
    .init_done_o    (init_done)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // XOR of all 9-bit chunks of the history value
  function automatic int unsigned hfold(input int unsigned g);
    int unsigned f = 0;
    while (g != 0) begin
      f = f ^ (g % NR_ROWS);
      g = g / NR_ROWS;
    end
    return f;
  endfunction

  function automatic int unsigned pred_row(input logic [31:0] pc);
    return ((pc >> 2) % NR_ROWS) ^ hfold(mdl_ghr);
  endfunction

  function automatic logic [31:0] vpc_for_row(input int unsigned r);
    return 32'((r ^ hfold(mdl_ghr)) % NR_ROWS) << 2;
  endfunction

  // One clock: advance the model with the inputs seen at this edge, then compare everything
  task automatic step();
    logic [1:0]  ev, et;
    logic [8:0]  ei;
    logic        ed;
    int unsigned row, ub, c;
    @(posedge clk);
    #1;
    ev = '0; et = '0; ei = '0; ed = 1'b0;
    if (rst || flush) begin
      init_left = NR_ROWS;
      mdl_ghr   = 0;
    end else if (init_left > 0) begin
      init_left--;
      if (init_left == 0) begin
        for (int r = 0; r < NR_ROWS; r++) begin
          mdl_ctr[r][0] = 1;
          mdl_ctr[r][1] = 1;
        end
      end
    end else begin
      row = pred_row(vpc);
      if (uv && !dbg) begin
        ub = (upc >> 1) & 1;
        c  = mdl_ctr[uidx][ub];
        mdl_ctr[uidx][ub] = ut ? ((c == 3) ? 3 : c + 1) : ((c == 0) ? 0 : c - 1);
`ifdef GSHARE_BP_HIST_EN
        mdl_ghr = ((mdl_ghr << 1) | 32'(ut)) & 8'hFF;
`endif
      end
      et[0] = (mdl_ctr[row][0] >= 2);
      et[1] = (mdl_ctr[row][1] >= 2);
      ev = 2'b11;
      ei = 9'(row);
      ed = 1'b1;
    end
    check("pred_valid", 32'(pred_valid), 32'(ev));
    check("pred_taken", 32'(pred_taken), 32'(et));
    check("pred_index", 32'(pred_index), 32'(ei));
    check("init_done", 32'(init_done), 32'(ed));
  endtask

  task automatic upd(input logic [31:0] pc, input logic [8:0] idx, input logic taken);
    uv = 1'b1; upc = pc; uidx = idx; ut = taken;
  endtask

  initial begin
    rst = 1'b1; flush = 1'b0; dbg = 1'b0; uv = 1'b0; ut = 1'b0;
    vpc = '0; upc = '0; uidx = '0;
    mdl_ghr = 0; init_left = NR_ROWS;
    for (int i = 0; i < 3; i++) step();
    rst = 1'b0;

    // Init sweep: outputs held low through the 512th edge, valid on the next
    for (int i = 0; i < NR_ROWS; i++) begin
      vpc = $urandom;
      step();
    end
    check("init_done_edge512", 32'(init_done), 32'd0);
    vpc = 32'h14;
    step();
    check("init_done_edge513", 32'(init_done), 32'd1);
    check("post_init_taken", 32'(pred_taken), 32'd0);

    // Bimodal training of row 5 bank 0
    upd(32'h14, 9'd5, 1'b1); step(); step();
    uv = 1'b0; vpc = vpc_for_row(5); step();
    check("train_taken", 32'(pred_taken[0]), 32'd1);
    upd(32'h14, 9'd5, 1'b1); step(); step();
    upd(32'h14, 9'd5, 1'b0); step();
    uv = 1'b0; vpc = vpc_for_row(5); step();
    check("saturate_taken", 32'(pred_taken[0]), 32'd1);

    // History: eight taken updates fill the GHR
    for (int i = 0; i < 8; i++) begin
      upd(32'h14, 9'd5, 1'b1); step();
    end
    uv = 1'b0; vpc = 32'h14; step();
`ifdef GSHARE_BP_HIST_EN
    check("hist_index", 32'(pred_index), 32'h0FA);
`else
    check("hist_index", 32'(pred_index), 32'h005);
`endif

    // Same-cycle update and prediction on row 0x0FA bank 0
    vpc = vpc_for_row(9'h0FA);
    upd(32'h0, 9'h0FA, 1'b1);
    step();
    check("collide_taken", 32'(pred_taken[0]), 32'd1);
    check("collide_index", 32'(pred_index), 32'h0FA);

    // Flush mid-run; updates during the sweep must be dropped
    uv = 1'b0; flush = 1'b1; step();
    flush = 1'b0;
    for (int i = 0; i < NR_ROWS; i++) begin
      upd(32'h14, 9'd5, 1'b1);
      vpc = $urandom;
      step();
    end
    check("flush_init_done", 32'(init_done), 32'd0);
    uv = 1'b0; vpc = 32'h14; step();
    check("flush_index", 32'(pred_index), 32'h005);
    check("flush_taken", 32'(pred_taken), 32'd0);
    vpc = 32'h0FA << 2; step();
    check("flush_taken_fa", 32'(pred_taken), 32'd0);

    // Debug mode blocks updates
    dbg = 1'b1;
    for (int i = 0; i < 4; i++) begin
      upd(32'h14, 9'd5, 1'b1); step();
    end
    dbg = 1'b0; uv = 1'b0; vpc = 32'h14; step();
    check("debug_index", 32'(pred_index), 32'h005);
    check("debug_taken", 32'(pred_taken[0]), 32'd0);

    // Random traffic with frequent collisions and one flush
    for (int i = 0; i < 3000; i++) begin
      vpc   = ($urandom & 32'hFFFF_0000) | (32'($urandom_range(0, 31)) << 2) | 32'($urandom_range(0, 3));
      uv    = ($urandom_range(0, 9) < 7);
      ut    = 1'($urandom);
      upc   = $urandom;
      dbg   = ($urandom_range(0, 19) == 0);
      flush = (i == 1500);
      uidx  = ($urandom_range(0, 2) == 0) ? 9'(pred_row(vpc)) : 9'($urandom_range(0, 31));
      step();
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule

// File: doc/gshare_bp.md
# gshare_bp

Parametrised global-history (gshare) conditional-branch predictor for the CVA6 frontend. It generalises the fixed global predictor to configurable fetch width, table depth, counter width and history length. It adds an internal table-initialisation sweep and a registered, bypassed prediction path. It sits beside the BTB/RAS in the frontend: it takes the fetch vPC and returns one taken/not-taken prediction per instruction slot, and it is trained by resolved-branch updates from the controller.

## Interface
- `VLEN`, 32, virtual address width.
- `INSTR_PER_FETCH`, 2, banks/slots per fetch; power of two.
- `NR_ENTRIES`, 1024, total counters; power of two; `NR_ROWS = NR_ENTRIES/INSTR_PER_FETCH`, `ROW_BITS = $clog2(NR_ROWS)`.
- `HIST_LEN`, 8, global history register (GHR) length; ≥1.
- `CTR_BITS`, 2, saturating counter width; ≥2.

Ports:
- `clk_i` in 1: single clock.
- `rst_i` in 1: synchronous, active-high reset.
- `flush_bp_i` in 1: flush request; restarts the init sweep and clears the GHR.
- `debug_mode_i` in 1: while high, updates are ignored.
- `vpc_i` in VLEN: fetch PC.
- `update_valid_i` in 1: resolved conditional-branch update.
- `update_pc_i` in VLEN: PC of the resolved branch.
- `update_taken_i` in 1: resolved direction.
- `update_index_i` in ROW_BITS: row index returned with the original prediction.
- `pred_valid_o` out INSTR_PER_FETCH: per-slot prediction valid.
- `pred_taken_o` out INSTR_PER_FETCH: per-slot predicted direction (counter MSB).
- `pred_index_o` out ROW_BITS: row used for this prediction; passed through as metadata.
- `init_done_o` out 1: table initialised, block in RUN.

## Operation
- `BANK_BITS = $clog2(INSTR_PER_FETCH)`; `ROW_LSB = BANK_BITS+1` (2-byte instruction granularity).
- Fold the GHR: zero-extend it to a multiple of ROW_BITS, then XOR all ROW_BITS-wide chunks to form `hfold`.
- Prediction row: `vpc_i[ROW_LSB +: ROW_BITS] ^ hfold`.
- Update bank: `update_pc_i[1 +: BANK_BITS]`. Update row is `update_index_i` exactly; it is never recomputed.
- Counters: init value `2^(CTR_BITS-1)-1` (weakly not-taken).
  - Taken: increment, saturating at `2^CTR_BITS-1`.
  - Not-taken: decrement, saturating at 0.
- GHR shift on an accepted update: `{GHR[HIST_LEN-2:0], update_taken_i}`.
- Update acceptance: an update is accepted only in RUN with `debug_mode_i=0`. Otherwise it is dropped, and neither the counter nor the GHR changes.
- FSM states: INIT and RUN.
  - `rst_i` forces INIT, row counter 0, GHR 0.
  - INIT writes the init value into every bank of row `cnt` each cycle. `cnt` increments; when `cnt==NR_ROWS-1` the FSM moves to RUN.
  - `flush_bp_i` in any state forces INIT, row counter 0, GHR 0. A flush during INIT restarts the sweep.
  - `rst_i` has priority over `flush_bp_i`.
- Outputs while in INIT:
  - `pred_valid_o` = 0.
  - `init_done_o` = 0.
  - `pred_taken_o` and `pred_index_o` are don't-care and are driven to 0.

## Timing
- Reset values: `pred_valid_o`=0, `pred_taken_o`=0, `pred_index_o`=0, `init_done_o`=0.
- Init takes exactly NR_ROWS cycles after reset or flush deasserts. `init_done_o` rises on the following edge.
- Prediction latency is 1 cycle: `vpc_i` sampled at edge N → outputs valid after edge N, using the GHR value held before edge N.
- Update: counter and GHR are written at the sampling edge.
- Same-cycle collision: if an accepted update targets the same row and bank that prediction samples, the registered prediction reflects the post-update counter (write-through bypass). The prediction index still uses the pre-shift GHR.
- Unconstrained inputs: updates and predictions may arrive every cycle with no backpressure.

## Configuration
- `GSHARE_BP_HIST_EN` defined: gshare indexing with the GHR as above.
- `GSHARE_BP_HIST_EN` undefined: bimodal predictor.
  - GHR is not implemented; `hfold` = 0.
  - Prediction row = `vpc_i[ROW_LSB +: ROW_BITS]`.
  - All other behaviour is identical.

## Test plan
All scenarios use default parameters (NR_ROWS=512, ROW_BITS=9, ROW_LSB=2).
- Reset → `init_done_o`=0 and `pred_valid_o`=0 for 512 cycles, then 1 and 2'b11. Any `vpc_i` then predicts `pred_taken_o`=2'b00 (counter 1).
- Bimodal training: update row 5, bank 0 (`update_pc_i`=0x14), taken ×2 → `vpc_i`=0x14 predicts slot0 taken. Two more taken (saturate at 3), then one not-taken → still taken.
- History: after 8 accepted updates taken=1 (GHR=8'hFF), `vpc_i`=0x14 → `pred_index_o` = 5^0xFF = 9'h0FA.
- Collision: update row 0x0FA, bank 0, taken in the same cycle as the `vpc_i` whose prediction row is 0x0FA (counter 1→2) → the prediction issued that cycle has slot0 taken.
- Flush mid-RUN with trained counters → 512 INIT cycles. Updates issued during INIT are dropped; afterwards all counters read weakly not-taken and the GHR is 0.
- `debug_mode_i`=1 with 4 taken updates to row 5 → counter and GHR are unchanged; prediction stays not-taken.
